// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: multi-cycle SM83 ALU working on WIDTH-bit operands in
// SLICE-bit chunks, one chunk per clock, with carry/borrow chained between
// chunks and a true nibble half-carry taken at bit WIDTH-5 -> WIDTH-4.
// Optional build macro SM83_ALU_SEQ_FAST_LOGIC_EN: AND/OR/XOR and illegal
// ops finish in the accept cycle and go straight to DONE.
module sm83_alu_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       in_flags,
   input  logic             keep_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       out_flags
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3,
                          OP_AND = 4'd4, OP_XOR = 4'd5, OP_OR  = 4'd6, OP_CP  = 4'd7,
                          OP_INC = 4'd8, OP_DEC = 4'd9;

   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic [3:0]       flags_r;
   logic             keep_z_r, carry_r, nz_r;

   logic [WIDTH-1:0] b_init;
   logic             c_init;
   int               sl_base;
   logic [SLICE-1:0] a_sl, b_sl, res_sl;
   logic [SLICE:0]   sum_sl;
   logic             nz_sl, h_raw, z_fin;
   logic [3:0]       fin_flags;

   assign in_ready  = rst_n && (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   // Second operand and carry-in as seen by the shared adder: subtracts use op1 + ~op2 + ~borrow
   always_comb begin
      b_init = op2;
      c_init = 1'b0;
      case (op)
         OP_ADC:        c_init = in_flags[0];
         OP_SUB, OP_CP: begin b_init = ~op2; c_init = 1'b1;         end
         OP_SBC:        begin b_init = ~op2; c_init = ~in_flags[0]; end
         OP_INC:        begin b_init = '0;   c_init = 1'b1;         end
         OP_DEC:        begin b_init = '1;   c_init = 1'b0;         end
         default:       ;
      endcase
   end

   // One slice of the datapath plus the final flag word produced on the last slice
   always_comb begin
      sl_base = int'(cnt) * SLICE;
      a_sl    = a_r[sl_base +: SLICE];
      b_sl    = b_r[sl_base +: SLICE];
      sum_sl  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_r};
      // carry into local bit SLICE-4 of the top slice is the half-carry position
      h_raw   = sum_sl[SLICE-4] ^ a_sl[SLICE-4] ^ b_sl[SLICE-4];
      case (op_r)
         OP_AND:  res_sl = a_sl & b_sl;
         OP_XOR:  res_sl = a_sl ^ b_sl;
         OP_OR:   res_sl = a_sl | b_sl;
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: res_sl = sum_sl[SLICE-1:0];
         default: res_sl = a_sl;
      endcase
      // CP reports z from the discarded difference, not from the returned op1
      nz_sl = (op_r == OP_CP) ? |sum_sl[SLICE-1:0] : |res_sl;
      z_fin = keep_z_r ? flags_r[3] : ~(nz_r | nz_sl);
      case (op_r)
         OP_ADD, OP_ADC:        fin_flags = {z_fin, 1'b0, h_raw, sum_sl[SLICE]};
         OP_SUB, OP_SBC, OP_CP: fin_flags = {z_fin, 1'b1, ~h_raw, ~sum_sl[SLICE]};
         OP_AND:                fin_flags = {z_fin, 1'b0, 1'b1, 1'b0};
         OP_XOR, OP_OR:         fin_flags = {z_fin, 1'b0, 1'b0, 1'b0};
         OP_INC:                fin_flags = {z_fin, 1'b0, h_raw, flags_r[0]};
         OP_DEC:                fin_flags = {z_fin, 1'b1, ~h_raw, flags_r[0]};
         default:               fin_flags = flags_r;
      endcase
   end

`ifdef SM83_ALU_SEQ_FAST_LOGIC_EN
   logic             is_fast;
   logic [WIDTH-1:0] fast_res;
   logic             fast_z;
   logic [3:0]       fast_flags;

   // Full-width logic result straight from the request for the single-cycle path
   always_comb begin
      is_fast  = (op == OP_AND) || (op == OP_XOR) || (op == OP_OR) || (op > OP_DEC);
      case (op)
         OP_AND:  fast_res = op1 & op2;
         OP_XOR:  fast_res = op1 ^ op2;
         OP_OR:   fast_res = op1 | op2;
         default: fast_res = op1;
      endcase
      fast_z = keep_z ? in_flags[3] : (fast_res == '0);
      case (op)
         OP_AND:        fast_flags = {fast_z, 3'b010};
         OP_XOR, OP_OR: fast_flags = {fast_z, 3'b000};
         default:       fast_flags = in_flags;
      endcase
   end
`endif

   // Request capture and running carry / nonzero accumulation
   always_ff @(posedge clk) begin
      if (state == S_IDLE && in_valid) begin
         op_r     <= op;
         a_r      <= op1;
         b_r      <= b_init;
         flags_r  <= in_flags;
         keep_z_r <= keep_z;
         carry_r  <= c_init;
         nz_r     <= 1'b0;
      end else if (state == S_BUSY) begin
         carry_r  <= sum_sl[SLICE];
         nz_r     <= nz_r | nz_sl;
      end
   end

   // Control FSM, slice counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         result    <= '0;
         out_flags <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  cnt <= '0;
`ifdef SM83_ALU_SEQ_FAST_LOGIC_EN
                  if (is_fast) begin
                     result    <= fast_res;
                     out_flags <= fast_flags;
                     state     <= S_DONE;
                  end else begin
                     state <= S_BUSY;
                  end
`else
                  state <= S_BUSY;
`endif
               end
            end
            S_BUSY: begin
               result[sl_base +: SLICE] <= res_sl;
               if (cnt == CW'(N - 1)) begin
                  out_flags <= fin_flags;
                  cnt       <= '0;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sm83_alu_seq.sv
// Testbench for sm83_alu_seq (WIDTH=16, SLICE=8): directed cases with
// hand-computed expectations, randomized ops against an integer model,
// backpressure and mid-operation reset.
module tb_sm83_alu_seq;
   localparam int WIDTH = 16;
   localparam int SLICE = 8;
   localparam int N     = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       op = '0;
   logic [WIDTH-1:0] op1 = '0, op2 = '0;
   logic [3:0]       in_flags = '0;
   logic             keep_z = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic [3:0]       out_flags;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] exp_res;
   logic [3:0]       exp_flags;
   logic             expect_out = 1'b0;

   sm83_alu_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .op1(op1), .op2(op2), .in_flags(in_flags), .keep_z(keep_z),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic on whole operands; returns {flags, result}
   function automatic logic [19:0] model(input logic [3:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] f,
                                         input logic kz);
      int ai, bi, ci, s, r, zv;
      logic n, h, c;
      ai = int'(a); bi = int'(b); ci = int'(f[0]);
      r = ai; n = f[2]; h = f[1]; c = f[0];
      case (o)
         4'd0, 4'd1: begin
            if (o == 4'd0) ci = 0;
            s = ai + bi + ci; r = s % 65536; zv = r;
            n = 1'b0; h = ((ai % 4096) + (bi % 4096) + ci) > 4095; c = s > 65535;
         end
         4'd2, 4'd3, 4'd7: begin
            if (o != 4'd3) ci = 0;
            s = ai - bi - ci; r = (s + 65536) % 65536; zv = r;
            n = 1'b1; h = ((ai % 4096) - (bi % 4096) - ci) < 0; c = s < 0;
            if (o == 4'd7) r = ai;
         end
         4'd4: begin r = ai & bi; zv = r; n = 1'b0; h = 1'b1; c = 1'b0; end
         4'd5: begin r = ai ^ bi; zv = r; n = 1'b0; h = 1'b0; c = 1'b0; end
         4'd6: begin r = ai | bi; zv = r; n = 1'b0; h = 1'b0; c = 1'b0; end
         4'd8: begin r = (ai + 1) % 65536; zv = r; n = 1'b0; h = (ai % 4096) == 4095; end
         4'd9: begin r = (ai + 65535) % 65536; zv = r; n = 1'b1; h = (ai % 4096) == 0; end
         default: return {f, a};
      endcase
      return {(kz ? f[3] : (zv == 0)), n, h, c, r[15:0]};
   endfunction

   function automatic int exp_latency(input logic [3:0] o);
`ifdef SM83_ALU_SEQ_FAST_LOGIC_EN
      if (o == 4'd4 || o == 4'd5 || o == 4'd6 || o > 4'd9) return 1;
`endif
      return N;
   endfunction

   // Output checker: whenever a result is presented it must match the model
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         check("spurious_valid", {31'd0, expect_out}, 32'd1);
         check("result", {16'd0, result}, {16'd0, exp_res});
         check("flags", {28'd0, out_flags}, {28'd0, exp_flags});
         check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
   end

   // Issue one request and, with optional backpressure, consume its result
   task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input logic kz, input int hold);
      int lat;
      int waited;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      op = o; op1 = a; op2 = b; in_flags = f; keep_z = kz; in_valid = 1'b1;
      {exp_flags, exp_res} = model(o, a, b, f, kz);
      @(posedge clk);
      expect_out = 1'b1;
      #1;
      in_valid = 1'b0;
      op = 4'($urandom); op1 = 16'($urandom); op2 = 16'($urandom);
      in_flags = 4'($urandom); keep_z = 1'($urandom);
      lat = 0;
      while (lat < 10) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
      end
      check("latency", lat, exp_latency(o));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         @(posedge clk);
         #1;
         check("hold_valid", {31'd0, out_valid}, 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      expect_out = 1'b0;
      #1;
      out_ready = 1'b0;
      check("release_valid", {31'd0, out_valid}, 32'd0);
      check("release_ready", {31'd0, in_ready}, 32'd1);
   endtask

   // Directed case: the model is first pinned against a hand-computed value
   task automatic run_lit(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input logic kz,
                          input logic [15:0] r_lit, input logic [3:0] f_lit);
      check("model_pin", {12'd0, model(o, a, b, f, kz)}, {12'd0, f_lit, r_lit});
      run_op(o, a, b, f, kz, 0);
   endtask

   function automatic logic [15:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h0FFF;
         3:       return 16'h1000;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_flags", {28'd0, out_flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed cases (flags written as {z,n,h,c})
      run_lit(4'd0, 16'h0FFF, 16'h0001, 4'b0000, 1'b0, 16'h1000, 4'b0010);
      run_lit(4'd2, 16'h0000, 16'h0001, 4'b0000, 1'b0, 16'hFFFF, 4'b0111);
      run_lit(4'd7, 16'h1234, 16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b1100);
      run_lit(4'd1, 16'hFFFF, 16'h0000, 4'b0001, 1'b1, 16'h0000, 4'b0011);
      run_lit(4'd1, 16'hFFFF, 16'h0000, 4'b0001, 1'b0, 16'h0000, 4'b1011);
      run_lit(4'd9, 16'h0100, 16'h5555, 4'b0001, 1'b0, 16'h00FF, 4'b0101);
      run_lit(4'd9, 16'h1000, 16'h0000, 4'b0001, 1'b0, 16'h0FFF, 4'b0111);
      run_lit(4'd8, 16'hFFFF, 16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b1010);
      run_lit(4'd3, 16'h1000, 16'h0000, 4'b0001, 1'b0, 16'h0FFF, 4'b0110);
      run_lit(4'd4, 16'hF0F0, 16'h0F0F, 4'b0001, 1'b0, 16'h0000, 4'b1010);
      run_lit(4'd5, 16'hF0F0, 16'hFF00, 4'b1111, 1'b0, 16'h0FF0, 4'b0000);
      run_lit(4'd6, 16'h0000, 16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b0000);
      run_lit(4'd12, 16'hABCD, 16'h1111, 4'b1010, 1'b0, 16'hABCD, 4'b1010);

      // Backpressure: result held for 5 cycles
      run_op(4'd0, 16'h1234, 16'h4321, 4'b0000, 1'b0, 5);

      // Reset while the second slice is being computed
      @(negedge clk);
      op = 4'd0; op1 = 16'h7777; op2 = 16'h1111; in_flags = 4'b0000; keep_z = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_result", {16'd0, result}, 32'd0);
      check("midrst_flags", {28'd0, out_flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_valid", {31'd0, out_valid}, 32'd0);
         check("post_rst_ready", {31'd0, in_ready}, 32'd1);
      end
      run_lit(4'd0, 16'h0001, 16'h0001, 4'b0000, 1'b0, 16'h0002, 4'b0000);

      // Randomized ops, including illegal codes and occasional backpressure
      for (int i = 0; i < 300; i++) begin
         run_op(4'($urandom), rand_operand(), rand_operand(), 4'($urandom),
                1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
